mult_div_ctrl: RTL and testbench

//  Multi-cycle sequencer for signed MULT/DIV. Sits between register A/B outputs and the HI/LO registers.
//  The main control unit pulses md_start with an opcode. The block iterates shift-add or restoring-divide
//  one bit per clock, then drives HI/LO data plus write strobes for one cycle. Divide-by-zero is flagged
//  to the control unit for the exception path.

---
 rtl/mult_div_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multi-cycle sequencer for signed MULT/DIV feeding the HI/LO registers.
// Each operation resolves one bit per clock. MULT uses shift-add on the operand magnitudes.
// DIV uses restoring division on the operand magnitudes. Signs are applied in a final step.
// Optional build macro MD_EARLY_EXIT_EN lets MULT leave the iteration loop early once the
// remaining multiplier bits are all zero. DIV always runs the full WIDTH iterations.
module mult_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             md_start,
    input  logic             md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_div0,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data,
    output logic             hi_write,
    output logic             lo_write
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, SIGN, DONE} stateT;

    stateT                   state;
    logic                    opIsDiv;
    logic signed [WIDTH-1:0] aReg;
    logic signed [WIDTH-1:0] bReg;
    logic                    negRes;    // quotient / product must be negated
    logic                    negRem;    // remainder follows the dividend sign
    logic [CNT_W-1:0]        cnt;
    logic [2*WIDTH-1:0]      acc;       // MULT product accumulator
    logic [2*WIDTH-1:0]      mcand;     // |a| shifted left one place per iteration
    logic [WIDTH-1:0]        bMag;      // MULT: multiplier shifted right; DIV: constant divisor
    logic [WIDTH-1:0]        rem;       // DIV partial remainder
    logic [WIDTH-1:0]        quot;      // DIV dividend bits out of the top, quotient bits in at the bottom

    logic [WIDTH:0]          remShift;
    logic [WIDTH:0]          trial;
    logic                    borrow;
    logic                    runLast;
    logic [2*WIDTH-1:0]      multProd;

    // Magnitude of a two's-complement operand; the most-negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magW(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] u;
        u = x;
        return x[WIDTH-1] ? (~u + WIDTH'(1)) : u;
    endfunction

    function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    // Restoring-divide trial subtract and loop-exit decision for the current RUN step.
    always_comb begin
        remShift = {rem, quot[WIDTH-1]};
        trial    = remShift - {1'b0, bMag};
        // Partial remainder is always below the divisor, so bit WIDTH of the
        // wrapped difference is set exactly when the subtract borrows.
        borrow   = trial[WIDTH];
        runLast  = (cnt == CNT_W'(1));
`ifdef MD_EARLY_EXIT_EN
        if (!opIsDiv && (bMag[WIDTH-1:1] == '0)) begin
            runLast = 1'b1;
        end
`endif
        multProd = negRes ? neg2W(acc) : acc;
    end

    // Sequencer: operand capture, iteration, sign fix-up and registered result/strobe outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            opIsDiv  <= 1'b0;
            aReg     <= '0;
            bReg     <= '0;
            negRes   <= 1'b0;
            negRem   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            bMag     <= '0;
            rem      <= '0;
            quot     <= '0;
            md_busy  <= 1'b0;
            md_done  <= 1'b0;
            md_div0  <= 1'b0;
            hi_data  <= '0;
            lo_data  <= '0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        opIsDiv <= md_op;
                        aReg    <= md_a;
                        bReg    <= md_b;
                        md_busy <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    negRes <= aReg[WIDTH-1] ^ bReg[WIDTH-1];
                    negRem <= aReg[WIDTH-1];
                    cnt    <= CNT_W'(WIDTH);
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, magW(aReg)};
                    bMag   <= magW(bReg);
                    rem    <= '0;
                    quot   <= magW(aReg);
                    if (opIsDiv && (bReg == '0)) begin
                        // Divide by zero: flag it and leave HI/LO untouched.
                        md_done <= 1'b1;
                        md_div0 <= 1'b1;
                        state   <= DONE;
`ifdef MD_EARLY_EXIT_EN
                    end else if (!opIsDiv && (bReg == '0)) begin
                        state <= SIGN;
`endif
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (opIsDiv) begin
                        rem  <= borrow ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], ~borrow};
                    end else begin
                        if (bMag[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= mcand << 1;
                        bMag  <= bMag >> 1;
                    end
                    if (runLast) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    if (opIsDiv) begin
                        lo_data <= negRes ? negW(quot) : quot;
                        hi_data <= negRem ? negW(rem) : rem;
                    end else begin
                        hi_data <= multProd[2*WIDTH-1:WIDTH];
                        lo_data <= multProd[WIDTH-1:0];
                    end
                    md_done  <= 1'b1;
                    hi_write <= 1'b1;
                    lo_write <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    md_done  <= 1'b0;
                    md_div0  <= 1'b0;
                    hi_write <= 1'b0;
                    lo_write <= 1'b0;
                    md_busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: directed vectors for mult_div_ctrl with hand-computed results and latencies.
// Honours MD_EARLY_EXIT_EN when computing expected MULT latency.
module tb_mult_div_ctrl;

    logic        clock;
    logic        reset;
    logic        mdStart;
    logic        mdOp;
    logic [31:0] mdA;
    logic [31:0] mdB;
    logic        mdBusy;
    logic        mdDone;
    logic        mdDiv0;
    logic [31:0] hiData;
    logic [31:0] loData;
    logic        hiWrite;
    logic        loWrite;

    int nVec = 0;
    int nBad = 0;

    mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .md_start (mdStart),
        .md_op    (mdOp),
        .md_a     (mdA),
        .md_b     (mdB),
        .md_busy  (mdBusy),
        .md_done  (mdDone),
        .md_div0  (mdDiv0),
        .hi_data  (hiData),
        .lo_data  (loData),
        .hi_write (hiWrite),
        .lo_write (loWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected edge (relative to E0) at which md_done is seen high for a MULT with multiplier b.
    function automatic int mulLat(input logic [31:0] b);
`ifdef MD_EARLY_EXIT_EN
        logic [31:0] m;
        int n;
        m = b[31] ? (~b + 32'd1) : b;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
        return 3 + n;
`else
        return 35;
`endif
    endfunction

    // Issue one operation, optionally re-pulse md_start with other operands at step pokeAt,
    // then check latency, results, flags and strobe timing.
    task automatic runOp(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int pokeAt, input logic [31:0] expHi, input logic [31:0] expLo,
                         input logic expDiv0, input int expLat);
        int lat;
        int earlyStrobe;
        logic [31:0] gotHi, gotLo;
        logic gotDiv0, gotHw, gotLw;
        lat = 0; earlyStrobe = 0;
        gotHi = '0; gotLo = '0; gotDiv0 = 1'b0; gotHw = 1'b0; gotLw = 1'b0;
        @(negedge clock);
        mdStart = 1'b1; mdOp = op; mdA = a; mdB = b;
        @(posedge clock);  // E0
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == pokeAt) begin
                mdStart = 1'b1; mdOp = 1'b1; mdA = 32'd100; mdB = 32'd7;
            end else begin
                mdStart = 1'b0; mdA = 32'hDEAD_BEEF; mdB = 32'h1234_5678;
            end
            if (k == 1) checkVal({tag, ".busy"}, 64'(mdBusy), 64'd1);
            if (mdDone) begin
                lat = k;
                gotHi = hiData; gotLo = loData; gotDiv0 = mdDiv0;
                gotHw = hiWrite; gotLw = loWrite;
                break;
            end
            if (hiWrite || loWrite) earlyStrobe++;
            @(posedge clock);
        end
        mdStart = 1'b0;
        checkVal({tag, ".lat"}, 64'(lat), 64'(expLat));
        checkVal({tag, ".div0"}, 64'(gotDiv0), 64'(expDiv0));
        checkVal({tag, ".hiW"}, 64'(gotHw), 64'(!expDiv0));
        checkVal({tag, ".loW"}, 64'(gotLw), 64'(!expDiv0));
        checkVal({tag, ".hi"}, 64'(gotHi), 64'(expHi));
        checkVal({tag, ".lo"}, 64'(gotLo), 64'(expLo));
        checkVal({tag, ".early"}, 64'(earlyStrobe), 64'd0);
        @(posedge clock);
        @(negedge clock);
        checkVal({tag, ".postDone"}, 64'({mdDone, mdDiv0, hiWrite, loWrite, mdBusy}), 64'd0);
        checkVal({tag, ".holdHi"}, 64'(hiData), 64'(expHi));
        checkVal({tag, ".holdLo"}, 64'(loData), 64'(expLo));
    endtask

    initial begin
        int doneSeen;
        mdStart = 1'b0; mdOp = 1'b0; mdA = '0; mdB = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        checkVal("rst.ctrl", 64'({mdBusy, mdDone, mdDiv0, hiWrite, loWrite}), 64'd0);
        checkVal("rst.hi", 64'(hiData), 64'd0);
        checkVal("rst.lo", 64'(loData), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        runOp("mul7xm3",  1'b0, 32'd7,          32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, mulLat(32'hFFFF_FFFD));
        runOp("divm7by2", 1'b1, 32'hFFFF_FFF9, 32'd2,          0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35);
        runOp("div5by0",  1'b1, 32'd5,          32'd0,          0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 2);
        runOp("divMinM1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000, 1'b0, 35);
        runOp("mulMinMin",1'b0, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000, 1'b0, mulLat(32'h8000_0000));
        runOp("div100bm7",1'b1, 32'd100,        32'hFFFF_FFF9, 0, 32'd2,         32'hFFFF_FFF2, 1'b0, 35);
        runOp("divm100m7",1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 32'hFFFF_FFFE, 32'd14,        1'b0, 35);
        runOp("mul5x1",   1'b0, 32'd5,          32'd1,          0, 32'd0,         32'd5,         1'b0, mulLat(32'd1));
        runOp("mulx0",    1'b0, 32'd1234,       32'd0,          0, 32'd0,         32'd0,         1'b0, mulLat(32'd0));
        runOp("mulPoke",  1'b0, 32'd7,          32'hFFFF_FFFD, 3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, mulLat(32'hFFFF_FFFD));

        // Abort an operation with reset partway through RUN.
        @(negedge clock);
        mdStart = 1'b1; mdOp = 1'b1; mdA = 32'd1000; mdB = 32'd3;
        @(posedge clock);  // E0
        #1 mdStart = 1'b0;
        repeat (9) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checkVal("abort.ctrl", 64'({mdBusy, mdDone, mdDiv0, hiWrite, loWrite}), 64'd0);
        checkVal("abort.hi", 64'(hiData), 64'd0);
        checkVal("abort.lo", 64'(loData), 64'd0);
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 2) reset = 1'b1;
            if (mdDone || hiWrite || loWrite || mdBusy) doneSeen++;
        end
        checkVal("abort.noDone", 64'(doneSeen), 64'd0);

        runOp("div9by4",  1'b1, 32'd9,          32'd4,          0, 32'd1,         32'd2,         1'b0, 35);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
